// File: rtl/sms_timing_pkg.sv
// Shared types and constants for the memory-cycle timing ring.
`default_nettype none

package sms_timing_pkg;

  localparam int RING_LEN_DEF = 20;

  localparam logic [RING_LEN_DEF-1:0] T0 = {{(RING_LEN_DEF-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sms_ring_shift.sv
// One-hot rotator with hold, load-T0 and illegal-pattern recovery.
`default_nettype none

module sms_ring_shift
  import sms_timing_pkg::*;
#(
  parameter int RING_LEN = RING_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic                load_t0,
  output logic [RING_LEN-1:0] ring,
  output logic                illegal
);

  localparam logic [RING_LEN-1:0] T0_VEC = {{(RING_LEN-1){1'b0}}, 1'b1};

  logic [RING_LEN-1:0] ring_r;

  // Zero bits set, or more than one (x & (x-1) clears only the lowest set bit).
  always_comb begin
    illegal = (ring_r == '0) || ((ring_r & (ring_r - T0_VEC)) != '0);
  end

  always_ff @(posedge clk) begin
    if (rst || load_t0 || illegal) begin
      ring_r <= T0_VEC;
    end else if (!hold) begin
      ring_r <= {ring_r[RING_LEN-2:0], ring_r[RING_LEN-1]};
    end
  end

  assign ring = ring_r;

endmodule

`default_nettype wire

// File: rtl/sms_timing_ring.sv
// Run/stop sequencer driving the 20-step one-hot memory-cycle timing ring.
`default_nettype none

module sms_timing_ring
  import sms_timing_pkg::*;
#(
  parameter int RING_LEN = RING_LEN_DEF,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                single_cycle,
  output logic [RING_LEN-1:0] ring,
  output logic                running,
  output logic                cycle_end,
  output logic [CNT_W-1:0]    cycle_count
);

  state_e             state;
  state_e             state_nx;
  logic               stop_pending;
  logic               start_q;
  logic               illegal;
  logic               shift_hold;
  logic               shift_load;
  logic [CNT_W-1:0]   count_r;

  sms_ring_shift #(
    .RING_LEN(RING_LEN)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .hold    (shift_hold),
    .load_t0 (shift_load),
    .ring    (ring),
    .illegal (illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // In single-cycle mode a held start must be released and re-asserted.
  always_comb begin
    state_nx = state;
    if (illegal) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (start && !stop && (!single_cycle || !start_q)) state_nx = RUN;
        RUN:  if (ring[RING_LEN-1] && (stop_pending || stop)) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    running    = (state == RUN);
    cycle_end  = running && ring[RING_LEN-1];
    shift_hold = !running;
    shift_load = !running;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stop_pending <= 1'b0;
      start_q      <= 1'b0;
      count_r      <= '0;
    end else begin
      start_q <= start;
      if (state_nx == IDLE) begin
        stop_pending <= 1'b0;
      end else if (running && (stop || (single_cycle && ring[0]))) begin
        stop_pending <= 1'b1;
      end
      if (cycle_end && !illegal) begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

  assign cycle_count = count_r;

endmodule

`default_nettype wire

// File: tb/tb_sms_timing_ring.sv
// Scoreboard bench for sms_timing_ring: directed steps push expected outputs, a monitor checks them.
`default_nettype none

module tb_sms_timing_ring;

  localparam int N = 20;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          single_cycle = 1'b0;
  logic [N-1:0]  ring;
  logic          running;
  logic          cycle_end;
  logic [W-1:0]  cycle_count;

  typedef struct {
    string        name;
    logic [N-1:0] ring;
    logic         running;
    logic         cycle_end;
    logic [W-1:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  sms_timing_ring #(.RING_LEN(N), .CNT_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .single_cycle (single_cycle),
    .ring         (ring),
    .running      (running),
    .cycle_end    (cycle_end),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  // Drive inputs at negedge, then after the rising edge queue the expected outputs.
  task automatic step(input string name, input logic r, input logic s, input logic p,
                      input logic sc, input int pos, input logic run, input int cnt);
    exp_t e;
    logic [N-1:0] one;
    @(negedge clk);
    rst = r; start = s; stop = p; single_cycle = sc;
    @(posedge clk);
    one         = N'(1);
    e.name      = name;
    e.ring      = one << pos;
    e.running   = run;
    e.cycle_end = run && (pos == N-1);
    e.count     = W'(cnt);
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (ring !== e.ring || running !== e.running || cycle_end !== e.cycle_end ||
          cycle_count !== e.count) begin
        miscompares++;
        $display("FAIL %s: got ring=%h running=%b cycle_end=%b count=%0d, expected ring=%h running=%b cycle_end=%b count=%0d",
                 e.name, ring, running, cycle_end, cycle_count,
                 e.ring, e.running, e.cycle_end, e.count);
      end
    end
  end

  initial begin
    // Reset then idle
    step("reset", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) step("idle", 0, 0, 0, 0, 0, 0, 0);

    // Free run: 45 clks with start held, back-to-back cycles
    for (int i = 1; i <= 45; i++) step("free_run", 0, 1, 0, 0, (i-1) % N, 1, (i-1) / N);

    // Deferred stop pulsed at T5
    step("pre_stop", 0, 0, 0, 0, 5, 1, 2);
    step("stop_t5", 0, 0, 1, 0, 6, 1, 2);
    for (int p = 7; p < N; p++) step("deferred", 0, 0, 0, 0, p, 1, 2);
    step("stop_idle", 0, 0, 0, 0, 0, 0, 3);
    step("stay_idle", 0, 0, 0, 0, 0, 0, 3);

    // Single cycle with start held afterwards
    for (int p = 0; p < N; p++) step("single", 0, 1, 0, 1, p, 1, 3);
    for (int i = 0; i < 5; i++) step("single_done", 0, 1, 0, 1, 0, 0, 4);

    // Simultaneous start+stop in IDLE
    step("release", 0, 0, 0, 0, 0, 0, 4);
    step("start_stop", 0, 1, 1, 0, 0, 0, 4);
    step("start_stop2", 0, 1, 1, 0, 0, 0, 4);

    // Reset mid-cycle at T12
    for (int p = 0; p <= 12; p++) step("pre_reset", 0, (p == 0), 0, 0, p, 1, 4);
    step("reset_mid", 1, 0, 0, 0, 0, 0, 0);
    step("after_reset", 0, 0, 0, 0, 0, 0, 0);

    // Corrupted ring recovers to T0 and IDLE
    for (int p = 0; p <= 3; p++) step("pre_fault", 0, (p == 0), 0, 0, p, 1, 0);
    @(negedge clk);
    force dut.u_shift.ring_r = 20'b101;
    #1;
    release dut.u_shift.ring_r;
    @(posedge clk);
    begin
      exp_t e;
      e.name = "fault_recover"; e.ring = N'(1); e.running = 1'b0;
      e.cycle_end = 1'b0; e.count = '0;
      exp_q.push_back(e);
    end
    step("fault_idle", 0, 0, 0, 0, 0, 0, 0);

    repeat (5) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
